misaligned_load_sequencer: RTL and testbench

- Sits in the MA stage between load issue and data memory.
- Turns every load (LB/LBU/LH/LHU/LW) into one or two word-aligned memory reads.
- For loads that cross a 32-bit word boundary, merges the two returned words, then extracts and sign- or zero-extends the result.
- Asserts a pipeline stall while a load is in flight, so no misaligned-access trap is needed.

---
 rtl/misaligned_load_sequencer_pkg.sv | 15 +
 rtl/load_data_merge.sv | 26 ++
 rtl/misaligned_load_sequencer.sv | 117 +++++++++++
 tb/tb_misaligned_load_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misaligned_load_sequencer_pkg.sv
// misaligned_load_sequencer_pkg: shared state encoding and load geometry helpers
package misaligned_load_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, MERGE} load_seq_state_e;

    localparam int WORD_BYTES = 4;

    // A load crosses a word boundary when its last byte falls past the word end
    function automatic logic load_crosses(input logic [1:0] offset, input logic is_byte, input logic is_half);
        logic [2:0] size;
        size = is_byte ? 3'd1 : is_half ? 3'd2 : 3'(WORD_BYTES);
        return ({1'b0, offset} + size) > 3'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/load_data_merge.sv
// load_data_merge: aligns a two-word window to the load offset and sign/zero-extends the result
module load_data_merge #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] hi_word,
    input  logic [XLEN-1:0] lo_word,
    input  logic [1:0]      offset,
    input  logic            is_byte,
    input  logic            is_half,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   aligned;

    // Shift the byte at the load offset down to bit 0, then extend per load size
    always_comb begin
        window  = {hi_word, lo_word} >> {offset, 3'b000};
        aligned = window[XLEN-1:0];
        result  = is_byte ? {{(XLEN-8){~is_unsigned & aligned[7]}}, aligned[7:0]}
                : is_half ? {{(XLEN-16){~is_unsigned & aligned[15]}}, aligned[15:0]}
                : aligned;
    end

endmodule

// File: rtl/misaligned_load_sequencer.sv
// misaligned_load_sequencer: splits loads into one or two aligned reads, merges and extends the result
module misaligned_load_sequencer
    import misaligned_load_sequencer_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_MEM_LATENCY = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_address,
    input  logic            i_is_load_byte,
    input  logic            i_is_load_halfword,
    input  logic            i_is_load_unsigned,
    input  logic            i_flush,
    output logic            o_mem_read_en,
    output logic [XLEN-1:0] o_mem_address,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_read_data,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_stall,
    output logic            o_timeout
);

    localparam int CW = $clog2(MAX_MEM_LATENCY + 2);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_MEM_LATENCY + 1);

    load_seq_state_e state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] hi_q;
    logic            byte_q;
    logic            half_q;
    logic            unsigned_q;
    logic [CW-1:0]   wait_cnt;
    logic            accept;
    logic            cross_q;
    logic            issue_hi;

    assign accept        = i_req_valid && state == IDLE && !i_flush;
    assign cross_q       = load_crosses(addr_q[1:0], byte_q, half_q);
    assign issue_hi      = state == WAIT_LO && i_mem_rvalid && cross_q && !i_flush;
    assign o_req_ready   = state == IDLE;
    assign o_stall       = state != IDLE || i_req_valid;
    assign o_rsp_valid   = state == MERGE && !i_flush;
    assign o_mem_read_en = accept || issue_hi;
    assign o_mem_address = accept   ? {i_req_address[XLEN-1:2], 2'b00}
                         : issue_hi ? {addr_q[XLEN-1:2], 2'b00} + XLEN'(WORD_BYTES)
                         : '0;

    load_data_merge #(.XLEN(XLEN)) u_merge (
        .hi_word     (hi_q),
        .lo_word     (lo_q),
        .offset      (addr_q[1:0]),
        .is_byte     (byte_q),
        .is_half     (half_q),
        .is_unsigned (unsigned_q),
        .result      (o_rsp_data)
    );

    // Load sequencing FSM with operand latches and the read-response watchdog
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            unsigned_q <= 1'b0;
            wait_cnt   <= '0;
            o_timeout  <= 1'b0;
        end else if (i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= i_req_address;
                        byte_q     <= i_is_load_byte;
                        half_q     <= i_is_load_halfword;
                        unsigned_q <= i_is_load_unsigned;
                        wait_cnt   <= CW'(1);
                        state      <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (i_mem_rvalid) begin
                        lo_q     <= i_mem_read_data;
                        wait_cnt <= CW'(1);
                        state    <= cross_q ? WAIT_HI : MERGE;
                    end else if (wait_cnt == LIMIT) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (i_mem_rvalid) begin
                        hi_q  <= i_mem_read_data;
                        state <= MERGE;
                    end else if (wait_cnt == LIMIT) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_misaligned_load_sequencer.sv
// tb_misaligned_load_sequencer: directed checks of load splitting, merging, flush and watchdog
module tb_misaligned_load_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = '0;
    logic        is_byte = 1'b0;
    logic        is_half = 1'b0;
    logic        is_uns = 1'b0;
    logic        flush = 1'b0;
    logic        read_en;
    logic [31:0] mem_address;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        stall;
    logic        timeout;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    misaligned_load_sequencer dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_address      (req_address),
        .i_is_load_byte     (is_byte),
        .i_is_load_halfword (is_half),
        .i_is_load_unsigned (is_uns),
        .i_flush            (flush),
        .o_mem_read_en      (read_en),
        .o_mem_address      (mem_address),
        .i_mem_rvalid       (rvalid),
        .i_mem_read_data    (rdata),
        .o_rsp_valid        (rsp_valid),
        .o_rsp_data         (rsp_data),
        .o_stall            (stall),
        .o_timeout          (timeout)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        #1;
        checks++;
        if ({req_ready, read_en, rsp_valid, stall, timeout} !== 5'b10000 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready/en/rsp/stall/timeout=%b addr=%h expected 10000 addr=00000000",
                     {req_ready, read_en, rsp_valid, stall, timeout}, mem_address);
        end
        step;
        rst = 1'b0;
        #1;
    endtask

    // Drives one load and emulates a memory of latency lat; checks addresses, data, strobes, latency and stall
    task automatic run_load(input string name, input logic [31:0] a, input logic b, input logic h, input logic u,
                            input logic [31:0] wlo, input logic [31:0] whi, input int lat,
                            input logic [31:0] exp_data, input int exp_strobes, input int exp_lat);
        logic [31:0] alo;
        logic [31:0] ahi;
        int strobes;
        int issue;
        int resp;
        int stalls;
        alo = {a[31:2], 2'b00};
        ahi = alo + 32'd4;
        strobes = 0;
        issue = -1;
        resp = -1;
        stalls = 0;
        req_valid = 1'b1;
        req_address = a;
        is_byte = b;
        is_half = h;
        is_uns = u;
        #1;
        checks++;
        if (read_en !== 1'b1 || mem_address !== alo || stall !== 1'b1) begin
            errors++;
            $display("FAIL %s first read: en=%b addr=%h stall=%b expected en=1 addr=%h stall=1",
                     name, read_en, mem_address, stall, alo);
        end
        if (read_en === 1'b1) begin
            strobes = 1;
            issue = 0;
        end
        for (int k = 1; k < 30 && resp < 0; k++) begin
            step;
            req_valid = 1'b0;
            rvalid = 1'b0;
            if (issue >= 0 && k == issue + lat) begin
                rvalid = 1'b1;
                rdata = (strobes == 1) ? wlo : whi;
                issue = -1;
            end
            #1;
            if (stall === 1'b1) stalls++;
            if (read_en === 1'b1) begin
                strobes++;
                issue = k;
                checks++;
                if (mem_address !== ahi) begin
                    errors++;
                    $display("FAIL %s second read addr: got %h expected %h", name, mem_address, ahi);
                end
            end
            if (rsp_valid === 1'b1) begin
                resp = k;
                checks++;
                if (rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h", name, rsp_data, exp_data);
                end
            end
        end
        step;
        rvalid = 1'b0;
        #1;
        checks++;
        if (strobes !== exp_strobes) begin
            errors++;
            $display("FAIL %s strobes: got %0d expected %0d", name, strobes, exp_strobes);
        end
        checks++;
        if (resp !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, resp, exp_lat);
        end
        checks++;
        if (stalls !== exp_lat) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, exp_lat);
        end
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after: ready=%b stall=%b rsp=%b expected 1 0 0", name, req_ready, stall, rsp_valid);
        end
    endtask

    task automatic test_aligned;
        run_load("lw_aligned", 32'h100, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1, 32'hDEADBEEF, 1, 2);
        run_load("lh_off2_l3", 32'h002, 1'b0, 1'b1, 1'b0, 32'h80010000, 32'h0, 3, 32'hFFFF8001, 1, 4);
    endtask

    task automatic test_halfword_cross;
        run_load("lh_cross", 32'h203, 1'b0, 1'b1, 1'b0, 32'h80AABBCC, 32'h11223301, 1, 32'h00000180, 2, 3);
        run_load("lhu_cross", 32'h203, 1'b0, 1'b1, 1'b1, 32'h80AABBCC, 32'h11223301, 1, 32'h00000180, 2, 3);
        run_load("lh_cross_neg", 32'h203, 1'b0, 1'b1, 1'b0, 32'h80AABBCC, 32'h112233F1, 1, 32'hFFFFF180, 2, 3);
        run_load("lhu_cross_neg", 32'h203, 1'b0, 1'b1, 1'b1, 32'h80AABBCC, 32'h112233F1, 1, 32'h0000F180, 2, 3);
    endtask

    task automatic test_word_cross;
        run_load("lw_cross_l2", 32'h102, 1'b0, 1'b0, 1'b0, 32'h44332211, 32'h88776655, 2, 32'h66554433, 2, 5);
        run_load("lw_wrap", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h44332211, 32'h88776655, 1, 32'h66554433, 2, 3);
    endtask

    task automatic test_byte;
        run_load("lb_off3", 32'h007, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h0, 1, 32'hFFFFFF80, 1, 2);
        run_load("lbu_off3", 32'h007, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'h0, 1, 32'h00000080, 1, 2);
    endtask

    task automatic test_flush;
        req_valid = 1'b1;
        req_address = 32'h203;
        is_byte = 1'b0;
        is_half = 1'b1;
        is_uns = 1'b0;
        #1;
        step;
        req_valid = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h80AABBCC;
        #1;
        checks++;
        if (read_en !== 1'b1 || mem_address !== 32'h204) begin
            errors++;
            $display("FAIL flush hi read: en=%b addr=%h expected en=1 addr=00000204", read_en, mem_address);
        end
        step;
        rvalid = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL flush in wait_hi: rsp=%b stall=%b expected 0 1", rsp_valid, stall);
        end
        step;
        flush = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h11223301;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || read_en !== 1'b0) begin
            errors++;
            $display("FAIL flush late rvalid: ready=%b rsp=%b en=%b expected 1 0 0", req_ready, rsp_valid, read_en);
        end
        step;
        rvalid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush stray ignored: ready=%b rsp=%b expected 1 0", req_ready, rsp_valid);
        end
        run_load("lw_after_flush", 32'h300, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 1, 32'hCAFEF00D, 1, 2);
        req_valid = 1'b1;
        flush = 1'b1;
        req_address = 32'h400;
        #1;
        checks++;
        if (read_en !== 1'b0) begin
            errors++;
            $display("FAIL flush with accept: en=%b expected 0", read_en);
        end
        step;
        req_valid = 1'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || read_en !== 1'b0) begin
            errors++;
            $display("FAIL flush with accept idle: ready=%b en=%b expected 1 0", req_ready, read_en);
        end
    endtask

    task automatic test_timeout;
        req_valid = 1'b1;
        req_address = 32'h500;
        is_byte = 1'b0;
        is_half = 1'b0;
        is_uns = 1'b0;
        #1;
        for (int k = 1; k <= 5; k++) begin
            step;
            req_valid = 1'b0;
            #1;
            checks++;
            if (timeout !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL timeout early cycle %0d: timeout=%b ready=%b expected 0 0", k, timeout, req_ready);
            end
        end
        step;
        #1;
        checks++;
        if (timeout !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout set: timeout=%b ready=%b rsp=%b expected 1 1 0", timeout, req_ready, rsp_valid);
        end
        step;
        #1;
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout sticky: got %b expected 1", timeout);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        checks++;
        if (timeout !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout cleared: timeout=%b ready=%b expected 0 1", timeout, req_ready);
        end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_halfword_cross;
        test_word_cross;
        test_byte;
        test_flush;
        test_timeout;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
